// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the instruction/data SRAM responder.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_ACCESS  = 2'd2,
    S_CAPTURE = 2'd3
  } state_e;

  typedef enum logic {
    GNT_INST = 1'b0,
    GNT_DATA = 1'b1
  } grant_e;

  localparam int unsigned WAIT_CYCLES_DEFAULT = 0;
  localparam int unsigned WAIT_CNT_W          = 4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/mem_responder_hold.sv
// Per-port done flag and result hold register (module mem_port_hold).
module mem_port_hold #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         req_i,
  input  logic         longest_stall_i,
  input  logic         set_done_i,
  input  logic         load_i,
  input  logic [W-1:0] rdata_i,
  output logic [W-1:0] rdata_o,
  output logic         done_o,
  output logic         stall_o
);

  logic         done_q;
  logic [W-1:0] rdata_q;

  // Done persists while the CPU is frozen on a still-present request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (set_done_i) begin
        done_q <= 1'b1;
      end else if (done_q && (!longest_stall_i || !req_i)) begin
        done_q <= 1'b0;
      end
      if (load_i) begin
        rdata_q <= rdata_i;
      end
    end
  end

  assign rdata_o = rdata_q;
  assign done_o  = done_q;
  assign stall_o = req_i & ~done_q;

endmodule

// File: rtl/mem_responder.sv
// Single-SRAM responder arbitrating instruction fetches and data loads/stores.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_en,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        i_stall,
  input  logic        i_longest_stall,
  input  logic [3:0]  data_ren,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        d_stall,
  input  logic        d_longest_stall,
  output logic        sram_en,
  output logic [3:0]  sram_we,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_CYCLES);

  state_e                  state_q;
  grant_e                  gnt_q;
  logic                    store_q;
  logic [3:0]              wen_q;
  logic [WAIT_CNT_W-1:0]   wait_cnt_q;
  logic                    sram_en_q;
  logic [3:0]              sram_we_q;
  logic [31:0]             sram_addr_q;
  logic [31:0]             sram_wdata_q;

  logic inst_req, data_req;
  logic inst_done, data_done;
  logic inst_load, data_load, data_set;

  assign inst_req  = inst_en;
  assign data_req  = (|data_ren) | (|data_wen);
  assign inst_load = (state_q == S_CAPTURE) && (gnt_q == GNT_INST);
  assign data_load = (state_q == S_CAPTURE) && (gnt_q == GNT_DATA);
  assign data_set  = data_load || ((state_q == S_ACCESS) && store_q);

  mem_port_hold #(.W(32)) u_inst_hold (
    .clk_i           (clk),
    .rst_ni          (rst),
    .req_i           (inst_req),
    .longest_stall_i (i_longest_stall),
    .set_done_i      (inst_load),
    .load_i          (inst_load),
    .rdata_i         (sram_rdata),
    .rdata_o         (inst_rdata),
    .done_o          (inst_done),
    .stall_o         (i_stall)
  );

  mem_port_hold #(.W(32)) u_data_hold (
    .clk_i           (clk),
    .rst_ni          (rst),
    .req_i           (data_req),
    .longest_stall_i (d_longest_stall),
    .set_done_i      (data_set),
    .load_i          (data_load),
    .rdata_i         (sram_rdata),
    .rdata_o         (data_rdata),
    .done_o          (data_done),
    .stall_o         (d_stall)
  );

  // The SRAM strobe is registered: it is raised on the edge entering ACCESS,
  // so with no wait states the grant edge also launches the access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      gnt_q        <= GNT_INST;
      store_q      <= 1'b0;
      wen_q        <= '0;
      wait_cnt_q   <= '0;
      sram_en_q    <= 1'b0;
      sram_we_q    <= '0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
    end else begin
      sram_en_q <= 1'b0;
      sram_we_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (d_stall || i_stall) begin
            gnt_q        <= d_stall ? GNT_DATA : GNT_INST;
            store_q      <= d_stall && (|data_wen);
            wen_q        <= d_stall ? data_wen : '0;
            sram_addr_q  <= word_align(d_stall ? data_addr : inst_addr);
            sram_wdata_q <= d_stall ? data_wdata : '0;
            if (WAIT_INIT == '0) begin
              state_q   <= S_ACCESS;
              sram_en_q <= 1'b1;
              sram_we_q <= d_stall ? data_wen : '0;
            end else begin
              state_q    <= S_WAIT;
              wait_cnt_q <= WAIT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt_q <= WAIT_CNT_W'(1)) begin
            state_q    <= S_ACCESS;
            wait_cnt_q <= '0;
            sram_en_q  <= 1'b1;
            sram_we_q  <= wen_q;
          end else begin
            wait_cnt_q <= wait_cnt_q - WAIT_CNT_W'(1);
          end
        end
        S_ACCESS: begin
          state_q <= store_q ? S_IDLE : S_CAPTURE;
        end
        S_CAPTURE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign sram_en    = sram_en_q;
  assign sram_we    = sram_we_q;
  assign sram_addr  = sram_addr_q;
  assign sram_wdata = sram_wdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder at WAIT_CYCLES=0 (dut 0) and 2 (dut 1).
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst          [2];
  logic        inst_en      [2];
  logic [31:0] inst_addr    [2];
  logic [31:0] inst_rdata   [2];
  logic        i_stall      [2];
  logic        i_ls         [2];
  logic [3:0]  data_ren     [2];
  logic [3:0]  data_wen     [2];
  logic [31:0] data_addr    [2];
  logic [31:0] data_wdata   [2];
  logic [31:0] data_rdata   [2];
  logic        d_stall      [2];
  logic        d_ls         [2];
  logic        sram_en      [2];
  logic [3:0]  sram_we      [2];
  logic [31:0] sram_addr    [2];
  logic [31:0] sram_wdata   [2];
  logic [31:0] sram_rdata   [2];

  int checks   = 0;
  int failures = 0;

  int          strobes    [2];
  int          writes     [2];
  logic [31:0] last_addr  [2];
  logic [31:0] last_wdata [2];
  logic [3:0]  last_we    [2];
  bit   [31:0] smem       [2][256];
  bit          written    [2][256];
  bit   [31:0] rmem       [2][256];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_responder #(.WAIT_CYCLES(g * 2)) u_dut (
      .clk             (clk),
      .rst             (rst[g]),
      .inst_en         (inst_en[g]),
      .inst_addr       (inst_addr[g]),
      .inst_rdata      (inst_rdata[g]),
      .i_stall         (i_stall[g]),
      .i_longest_stall (i_ls[g]),
      .data_ren        (data_ren[g]),
      .data_wen        (data_wen[g]),
      .data_addr       (data_addr[g]),
      .data_wdata      (data_wdata[g]),
      .data_rdata      (data_rdata[g]),
      .d_stall         (d_stall[g]),
      .d_longest_stall (d_ls[g]),
      .sram_en         (sram_en[g]),
      .sram_we         (sram_we[g]),
      .sram_addr       (sram_addr[g]),
      .sram_wdata      (sram_wdata[g]),
      .sram_rdata      (sram_rdata[g])
    );
  end

  function automatic bit [31:0] init_word(input int i);
    if (i == 'h41) return 32'hDEADBEEF;
    return bit'(1'b0) ? 32'h0 : ((32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F);
  endfunction

  // SRAM environment: 1 KB per DUT, read data one cycle after the strobe.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (sram_en[g]) begin
        automatic int idx = int'(sram_addr[g][9:2]);
        automatic bit [31:0] w = written[g][idx] ? smem[g][idx] : init_word(idx);
        strobes[g]++;
        last_addr[g]  = sram_addr[g];
        last_we[g]    = sram_we[g];
        last_wdata[g] = sram_wdata[g];
        if (|sram_we[g]) begin
          writes[g]++;
          for (int b = 0; b < 4; b++)
            if (sram_we[g][b]) w[8*b +: 8] = sram_wdata[g][8*b +: 8];
          smem[g][idx]    = w;
          written[g][idx] = 1'b1;
        end else begin
          sram_rdata[g] <= w;
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic stall_of(input int k, input bit is_inst);
    return is_inst ? i_stall[k] : d_stall[k];
  endfunction

  function automatic logic [31:0] rdata_of(input int k, input bit is_inst);
    return is_inst ? inst_rdata[k] : data_rdata[k];
  endfunction

  task automatic ref_store(input int k, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] mask);
    bit [31:0] w;
    w = rmem[k][addr[9:2]];
    for (int b = 0; b < 4; b++)
      if (mask[b]) w[8*b +: 8] = wdata[8*b +: 8];
    rmem[k][addr[9:2]] = w;
  endtask

  task automatic idle_inputs(input int k);
    inst_en[k] = 1'b0; data_ren[k] = '0; data_wen[k] = '0;
    i_ls[k] = 1'b0; d_ls[k] = 1'b0;
  endtask

  // Called and returns at a falling edge. Expected latency: 3+WC reads, 2+WC stores.
  task automatic do_txn(input int k, input bit is_inst, input bit store, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] mask,
                        input int freeze, input bit withdraw);
    int s0, w0, lat, hi;
    logic [31:0] exp;
    s0  = strobes[k];
    w0  = writes[k];
    lat = (store ? 2 : 3) + 2 * k;
    if (is_inst) begin
      inst_en[k] = 1'b1; inst_addr[k] = addr;
    end else begin
      data_addr[k] = addr; data_wdata[k] = wdata;
      if (store) begin
        data_wen[k] = mask;
        data_ren[k] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      end else begin
        data_ren[k] = mask;
      end
    end
    if (store) ref_store(k, addr, wdata, mask);
    exp = rmem[k][addr[9:2]];
    #1;
    if (withdraw) begin
      check_eq("withdraw_stall_first", stall_of(k, is_inst), 1'b1);
      @(negedge clk);
      idle_inputs(k);
      repeat (lat + 2) @(negedge clk);
      #1;
      check_eq("withdraw_strobes", strobes[k] - s0, 1);
      check_eq("withdraw_writes", writes[k] - w0, store ? 1 : 0);
      @(negedge clk);
      return;
    end
    hi = 0;
    while (stall_of(k, is_inst) && hi < 64) begin
      hi++;
      @(negedge clk);
      #1;
    end
    check_eq("latency", hi, lat);
    check_eq("strobes", strobes[k] - s0, 1);
    check_eq("sram_addr", last_addr[k], addr & 32'hFFFF_FFFC);
    check_eq("sram_we", last_we[k], store ? mask : 4'h0);
    if (store) begin
      check_eq("sram_wdata", last_wdata[k], wdata);
      check_eq("writes", writes[k] - w0, 1);
    end else begin
      check_eq("rdata", rdata_of(k, is_inst), exp);
    end
    if (freeze > 0) begin
      if (is_inst) i_ls[k] = 1'b1; else d_ls[k] = 1'b1;
      repeat (freeze) begin
        @(negedge clk);
        #1;
        check_eq("freeze_stall", stall_of(k, is_inst), 1'b0);
        check_eq("freeze_strobes", strobes[k] - s0, 1);
        if (!store) check_eq("freeze_rdata", rdata_of(k, is_inst), exp);
      end
    end
    idle_inputs(k);
    @(negedge clk);
  endtask

  // Inst and data loads raised together; data wins, inst follows.
  task automatic do_both(input int k, input logic [31:0] iaddr, input logic [31:0] daddr);
    int ih, dh, cyc;
    bit idn, ddn;
    ih = 0; dh = 0; cyc = 0; idn = 0; ddn = 0;
    inst_en[k] = 1'b1; inst_addr[k] = iaddr;
    data_ren[k] = 4'($urandom_range(1, 15)); data_addr[k] = daddr;
    #1;
    while (!(idn && ddn) && cyc < 80) begin
      if (!ddn) begin
        if (d_stall[k]) dh++;
        else begin
          ddn = 1;
          check_eq("both_data_rdata", data_rdata[k], rmem[k][daddr[9:2]]);
          data_ren[k] = '0;
        end
      end
      if (!idn) begin
        if (i_stall[k]) ih++;
        else begin
          idn = 1;
          check_eq("both_inst_rdata", inst_rdata[k], rmem[k][iaddr[9:2]]);
          inst_en[k] = 1'b0;
        end
      end
      cyc++;
      if (!(idn && ddn)) begin
        @(negedge clk);
        #1;
      end
    end
    check_eq("both_data_latency", dh, 3 + 2 * k);
    check_eq("both_inst_latency", ih, 6 + 4 * k);
    idle_inputs(k);
    @(negedge clk);
  endtask

  // Reset lands in the ACCESS cycle of a store; the store must replay afterwards.
  task automatic do_reset_store(input int k, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] mask);
    int w0, cyc, hi;
    w0 = writes[k];
    data_addr[k] = addr; data_wdata[k] = wdata; data_wen[k] = mask;
    cyc = 0;
    #1;
    while (!sram_en[k] && cyc < 20) begin
      cyc++;
      @(negedge clk);
      #1;
    end
    check_eq("rst_reach_access", sram_en[k], 1'b1);
    rst[k] = 1'b0;
    #1;
    check_eq("rst_sram_en", sram_en[k], 1'b0);
    check_eq("rst_sram_we", sram_we[k], 4'h0);
    check_eq("rst_sram_addr", sram_addr[k], 32'h0);
    check_eq("rst_sram_wdata", sram_wdata[k], 32'h0);
    check_eq("rst_inst_rdata", inst_rdata[k], 32'h0);
    check_eq("rst_data_rdata", data_rdata[k], 32'h0);
    check_eq("rst_d_stall", d_stall[k], 1'b1);
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_no_write", writes[k] - w0, 0);
    rst[k] = 1'b1;
    hi = 0;
    while (d_stall[k] && hi < 64) begin
      hi++;
      @(negedge clk);
      #1;
    end
    check_eq("rst_replay_latency", hi, 2 + 2 * k);
    check_eq("rst_replay_writes", writes[k] - w0, 1);
    check_eq("rst_replay_addr", last_addr[k], addr & 32'hFFFF_FFFC);
    ref_store(k, addr, wdata, mask);
    idle_inputs(k);
    @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b0;
      idle_inputs(k);
      inst_addr[k] = '0; data_addr[k] = '0; data_wdata[k] = '0;
      for (int i = 0; i < 256; i++) rmem[k][i] = init_word(i);
    end
    @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check_eq("reset_sram_en", sram_en[k], 1'b0);
      check_eq("reset_sram_we", sram_we[k], 4'h0);
      check_eq("reset_sram_addr", sram_addr[k], 32'h0);
      check_eq("reset_sram_wdata", sram_wdata[k], 32'h0);
      check_eq("reset_inst_rdata", inst_rdata[k], 32'h0);
      check_eq("reset_data_rdata", data_rdata[k], 32'h0);
      check_eq("reset_i_stall", i_stall[k], 1'b0);
      check_eq("reset_d_stall", d_stall[k], 1'b0);
    end
    @(negedge clk);
    rst[0] = 1'b1; rst[1] = 1'b1;
    @(negedge clk);

    do_txn(0, 1'b1, 1'b0, 32'h0000_0104, 32'h0, 4'h0, 0, 1'b0);
    do_txn(0, 1'b0, 1'b1, 32'h0000_0202, 32'h1234_5678, 4'b0011, 0, 1'b0);
    do_txn(0, 1'b0, 1'b0, 32'h0000_0200, 32'h0, 4'hF, 0, 1'b0);
    do_both(0, 32'h0000_0104, 32'h0000_0200);
    do_txn(0, 1'b0, 1'b0, 32'h0000_0300, 32'h0, 4'h1, 4, 1'b0);
    do_txn(1, 1'b0, 1'b0, 32'h0000_0104, 32'h0, 4'hF, 0, 1'b0);
    do_reset_store(1, 32'h0000_0089, 32'hCAFE_F00D, 4'b1010);
    do_txn(1, 1'b0, 1'b0, 32'h0000_0088, 32'h0, 4'hF, 0, 1'b0);

    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < 40; n++) begin
        automatic int sel = $urandom_range(0, 9);
        automatic logic [31:0] a = $urandom;
        if (sel < 2) begin
          do_both(k, $urandom, a);
        end else begin
          do_txn(k, sel < 4, sel >= 7, a, $urandom, 4'($urandom_range(1, 15)),
                 ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
                 $urandom_range(0, 7) == 0);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
